// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: latches a 4-digit BCD value on an update strobe and scans it
// onto a multiplexed common-anode seven-segment display. It adds leading-zero
// blanking and a short all-off gap at the start of every digit slot so that
// the previous digit's segments do not ghost onto the next anode.
module bcd_seg_scan #(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 4,
  parameter int LZ_BLANK  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [3:0] one,
  input  logic [3:0] ten,
  input  logic [3:0] hundred,
  input  logic [2:0] thousand,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Clocks per digit slot; DIV >= 2 and BLANK_CYC < DIV are assumed.
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  // Reset shadow is all zeros, so the reset mask is what all-zero digits give.
  localparam logic [3:0] MASK_RST = (LZ_BLANK != 0) ? 4'b1110 : 4'b0000;

  // Incoming digits as an indexable set; thousands is zero-extended.
  logic [3:0] digit_in [4];
  assign digit_in[0] = one;
  assign digit_in[1] = ten;
  assign digit_in[2] = hundred;
  assign digit_in[3] = {1'b0, thousand};

  logic [3:0]       shadow_reg [4];
  logic [3:0]       mask_reg;
  logic [3:0]       mask_next;
  logic [CNT_W-1:0] count_reg;
  logic [1:0]       index_reg;
  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;
  logic             tick;
  logic             gap;
  logic [6:0]       seg_next;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is drawn as a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Shadow registers: every digit is captured on the same strobe edge so a
  // partially updated value is never displayed.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      // Capture one digit on update; reset clears it.
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= 4'd0;
        end else if (update) begin
          shadow_reg[gi] <= digit_in[gi];
        end
      end
    end
  endgenerate

  // Leading-zero mask from the incoming digits, so it lands with the shadow.
  // Dash codes (10..15) are nonzero and therefore stop the blanking chain.
  always_comb begin
    mask_next = 4'b0000;
    if (LZ_BLANK != 0) begin
      mask_next[3] = (digit_in[3] == 4'd0);
      mask_next[2] = mask_next[3] && (digit_in[2] == 4'd0);
      mask_next[1] = mask_next[2] && (digit_in[1] == 4'd0);
    end
  end

  // Register the blank mask together with the shadow digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= MASK_RST;
    end else if (update) begin
      mask_reg <= mask_next;
    end
  end

  assign tick = (count_reg == CNT_LAST);

  // Slot prescaler and digit index; the index steps once per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      index_reg <= 2'd0;
    end else begin
      if (tick) begin
        count_reg <= '0;
        index_reg <= index_reg + 2'd1;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Gap at the head of each slot, or the digit is a suppressed leading zero.
  always_comb begin
    gap      = (count_reg < CNT_BLANK) || mask_reg[index_reg];
    seg_next = decode(shadow_reg[index_reg]);
  end

  // Registered pin drivers: one clock behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'h7F;
    end else if (gap) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'h7F;
    end else begin
      an_reg  <= ~(4'b0001 << index_reg);
      seg_reg <= seg_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: two instances (leading-zero blanking on and off)
// share one stimulus. A digit-level model predicts every output cycle, a
// constant table checks whole frames, and short scripted sequences cover
// reset, update-on-tick and reset during a slot.
module tb_bcd_seg_scan;

  localparam int DIV = 10;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic [3:0] one = 4'd0, ten = 4'd0, hundred = 4'd0;
  logic [2:0] thousand = 3'd0;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0;

  always #5 clk = ~clk;

  bcd_seg_scan #(.CLK_HZ(40), .SCAN_HZ(4), .BLANK_CYC(BLK), .LZ_BLANK(1)) dut_lz1 (
    .clk(clk), .rst(rst), .update(update), .one(one), .ten(ten),
    .hundred(hundred), .thousand(thousand), .an(an1), .seg(seg1), .dp(dp1)
  );

  bcd_seg_scan #(.CLK_HZ(40), .SCAN_HZ(4), .BLANK_CYC(BLK), .LZ_BLANK(0)) dut_lz0 (
    .clk(clk), .rst(rst), .update(update), .one(one), .ten(ten),
    .hundred(hundred), .thousand(thousand), .an(an0), .seg(seg0), .dp(dp0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: non-reset edges since reset, and latched digits.
  int         n = 0;
  logic [3:0] sh [4];
  logic [6:0] seg_tab [16];
  int         last_cnt = 0;
  int         last_idx = 0;
  bit         last_rst = 1'b1;

  typedef struct {
    logic [2:0]      th;
    logic [3:0]      hu;
    logic [3:0]      te;
    logic [3:0]      on;
    logic [3:0][3:0] an_e;    // LZ on, slot 3..0
    logic [3:0][6:0] seg_e;   // LZ on, slot 3..0
    logic [3:0][6:0] seg0_e;  // LZ off, slot 3..0
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got an/seg/dp=%h expected %h", name, act, exp);
    end
  endtask

  // Expected {an, seg} for one scan position given the latched digits.
  function automatic logic [10:0] model_out(input bit lz, input int cnt, input int idx);
    int lead;
    logic [3:0] a;
    lead = 0;
    for (int k = 0; k < 4; k++) if (sh[k] != 4'd0) lead = k;
    if (cnt < BLK || (lz && idx > lead)) return {4'hF, 7'h7F};
    a = 4'hF;
    a[idx] = 1'b0;
    return {a, seg_tab[sh[idx]]};
  endfunction

  // One clock: predict, advance the model on the edge, compare both DUTs.
  task automatic step();
    logic [10:0] e1, e0;
    int cnt, idx;
    cnt = n % DIV;
    idx = (n / DIV) % 4;
    if (rst) begin
      e1 = {4'hF, 7'h7F};
      e0 = e1;
    end else begin
      e1 = model_out(1'b1, cnt, idx);
      e0 = model_out(1'b0, cnt, idx);
    end
    @(posedge clk);
    last_rst = rst;
    last_cnt = cnt;
    last_idx = idx;
    if (rst) begin
      n = 0;
      for (int k = 0; k < 4; k++) sh[k] = 4'd0;
    end else begin
      n++;
      if (update) begin
        sh[0] = one;
        sh[1] = ten;
        sh[2] = hundred;
        sh[3] = {1'b0, thousand};
      end
    end
    #1;
    chk("model lz1", {an1, seg1, dp1}, {e1, 1'b1});
    chk("model lz0", {an0, seg0, dp0}, {e0, 1'b1});
  endtask

  // Step until the edge just taken was evaluated at (cnt, idx).
  task automatic run_until(input int c, input int i);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      step();
      if (!last_rst && last_cnt == c && last_idx == i) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL run_until: slot %0d count %0d not reached within 60 clocks", i, c);
    end
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 1) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [3:0] an_exp;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    for (int k = 0; k < 4; k++) sh[k] = 4'd0;

    vecs[0] = '{3'd4, 4'd0, 4'd9, 4'd5, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h19, 7'h40, 7'h10, 7'h12}, {7'h19, 7'h40, 7'h10, 7'h12}};
    vecs[1] = '{3'd0, 4'd0, 4'd4, 4'd2, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h19, 7'h24}};
    vecs[2] = '{3'd0, 4'd0, 4'hC, 4'd0, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h3F, 7'h40}, {7'h40, 7'h40, 7'h3F, 7'h40}};
    vecs[3] = '{3'd0, 4'd0, 4'd0, 4'd0, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{3'd7, 4'd8, 4'd1, 4'd3, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h78, 7'h00, 7'h79, 7'h30}, {7'h78, 7'h00, 7'h79, 7'h30}};
    vecs[5] = '{3'd0, 4'd6, 4'd0, 4'd0, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'h7F, 7'h02, 7'h40, 7'h40}, {7'h7F, 7'h02, 7'h40, 7'h40}};
    // LZ off always shows thousands; fix that entry's slot 3 to "0".
    vecs[5].seg0_e[3] = 7'h40;

    // Reset held for 3 clocks: everything off.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset hold", {an1, seg1, dp1}, {4'hF, 7'h7F, 1'b1});
    end
    rst = 1'b0;
    // After release: units shows "0" on clocks 3..10, other slots stay dark.
    for (int k = 1; k <= 12; k++) begin
      step();
      an_exp = (k >= 3 && k <= 10) ? 4'b1110 : 4'b1111;
      chk($sformatf("release clk%0d", k), {an1, seg1, dp1},
          {an_exp, (k >= 3 && k <= 10) ? 7'h40 : 7'h7F, 1'b1});
    end

    // Table-driven frames: latch a set, then sample mid-slot on every digit.
    for (int v = 0; v < 6; v++) begin
      one = vecs[v].on;
      ten = vecs[v].te;
      hundred = vecs[v].hu;
      thousand = vecs[v].th;
      update = 1'b1;
      step();
      update = 1'b0;
      for (int s = 0; s < 4; s++) begin
        run_until(5, s);
        an_exp = 4'hF;
        an_exp[s] = 1'b0;
        chk($sformatf("vec%0d slot%0d lz1", v, s), {an1, seg1, dp1},
            {vecs[v].an_e[s], vecs[v].seg_e[s], 1'b1});
        if (vecs[v].seg0_e[s] == 7'h7F) an_exp = 4'hF;
        chk($sformatf("vec%0d slot%0d lz0", v, s), {an0, seg0, dp0},
            {an_exp, vecs[v].seg0_e[s], 1'b1});
      end
    end

    // Update on the same edge as the units->tens tick: tens shows new data.
    run_until(8, 0);
    one = 4'd4;
    ten = 4'd3;
    hundred = 4'd2;
    thousand = 3'd1;
    update = 1'b1;
    step();
    update = 1'b0;
    step();
    step();
    step();
    chk("tick+update tens", {an1, seg1, dp1}, {4'b1101, 7'h30, 1'b1});

    // Reset during the hundreds slot, then scanning resumes at units "0".
    run_until(5, 2);
    rst = 1'b1;
    step();
    chk("mid reset", {an1, seg1, dp1}, {4'hF, 7'h7F, 1'b1});
    rst = 1'b0;
    step();
    step();
    step();
    chk("resume units lz1", {an1, seg1, dp1}, {4'b1110, 7'h40, 1'b1});
    chk("resume units lz0", {an0, seg0, dp0}, {4'b1110, 7'h40, 1'b1});

    // Randomized traffic against the model, with occasional resets.
    for (int t = 0; t < 400; t++) begin
      one = rnd_digit();
      ten = rnd_digit();
      hundred = rnd_digit();
      thousand = 3'(rnd_digit());
      update = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    update = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
